// File: rtl/nios_memtest_pkg.sv
// nios_memtest_pkg
// Shared definitions for the on-chip memory tester: default geometry of the
// target RAM, the controller state encoding and the address-derived test
// pattern used by both the write path and the compare stage.
package nios_memtest_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2048;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Address replicated into both 16-bit halves, then XORed with the seed.
    function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] seed,
                                              input logic [ADDR_W-1:0] a);
        return seed ^ {5'b0, a, 5'b0, a};
    endfunction

endpackage

// File: rtl/nios_onchip_memory_tester_if.sv
// nios_onchip_memory_tester_if
// Avalon-MM bus between the tester (master) and the on-chip RAM s1 port
// (slave).
//   m_address     word address
//   m_byteenable  byte lanes, all ones during every access
//   m_chipselect  access strobe
//   m_write       write qualifier
//   m_writedata   write data
//   m_clken       RAM clock enable
//   m_readdata    read data, one cycle after the read address
interface nios_onchip_memory_tester_if
    import nios_memtest_pkg::*;
#(
    parameter int ADDR_W = nios_memtest_pkg::ADDR_W,
    parameter int DATA_W = nios_memtest_pkg::DATA_W
);
    logic [ADDR_W-1:0]   m_address;
    logic [DATA_W/8-1:0] m_byteenable;
    logic                m_chipselect;
    logic                m_write;
    logic [DATA_W-1:0]   m_writedata;
    logic                m_clken;
    logic [DATA_W-1:0]   m_readdata;

    modport master (
        output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        input  m_readdata
    );

    modport slave (
        input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        output m_readdata
    );
endinterface

// File: rtl/nios_memtest_cmp.sv
// nios_memtest_cmp
// Compare stage: checks read data against the pattern of the (already
// delayed) expected address and counts mismatching words.
//   clk, reset  clock, asynchronous active-high reset
//   clear       start acceptance; clears counter and first-error capture
//   valid       rdata holds the word read from exp_addr this cycle
//   seed        captured pattern seed
//   exp_addr    physical address the current rdata came from
//   rdata       RAM read data
//   mismatch    combinational strobe: valid word differs from its pattern
//   err_count   registered mismatch count
// Macro NIOS_MEMTEST_FIRST_ERR_EN adds first_err_valid/addr/data.
module nios_memtest_cmp
    import nios_memtest_pkg::*;
#(
    parameter int ADDR_W = nios_memtest_pkg::ADDR_W,
    parameter int DATA_W = nios_memtest_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              valid,
    input  logic [DATA_W-1:0] seed,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] rdata,
    output logic              mismatch,
    output logic [ADDR_W:0]   err_count
`ifdef NIOS_MEMTEST_FIRST_ERR_EN
    ,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
`endif
);

    always_comb begin
        mismatch = valid && (rdata != pat(seed, exp_addr));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (clear) begin
            err_count <= '0;
        end else if (mismatch) begin
            err_count <= err_count + 1'b1;
        end
    end

`ifdef NIOS_MEMTEST_FIRST_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_data  <= '0;
        end else if (clear) begin
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_data  <= '0;
        end else if (mismatch && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= exp_addr;
            first_err_data  <= rdata;
        end
    end
`endif

endmodule

// File: rtl/nios_onchip_memory_tester.sv
// nios_onchip_memory_tester
// Avalon-MM master that writes pat(addr) over a wrapping window of the
// on-chip RAM, reads it back and counts mismatching words.
//   clk, reset     clock, asynchronous active-high reset
//   start          run request, sampled only in IDLE
//   seed/base/count  run parameters, captured on start acceptance
//   busy           run in progress
//   done           one-cycle completion pulse
//   pass           last run had no mismatches
//   err_count      mismatching words of the last run
//   mem            Avalon master bus (nios_onchip_memory_tester_if.master)
// Macro NIOS_MEMTEST_FIRST_ERR_EN adds first_err_valid/addr/data.
module nios_onchip_memory_tester
    import nios_memtest_pkg::*;
#(
    parameter int ADDR_W = nios_memtest_pkg::ADDR_W,
    parameter int DATA_W = nios_memtest_pkg::DATA_W,
    parameter int DEPTH  = nios_memtest_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
`ifdef NIOS_MEMTEST_FIRST_ERR_EN
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
`endif
    nios_onchip_memory_tester_if.master mem
);

    state_t            state, state_next;
    logic              accept;
    logic              last;
    logic [DATA_W-1:0] seed_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   cnt_r;
    logic [ADDR_W:0]   idx;        // accesses already issued in this phase
    logic [ADDR_W-1:0] addr_inc;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              mismatch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = (idx == cnt_r);
        addr_inc   = (mem.m_address == ADDR_W'(DEPTH - 1)) ? '0 : mem.m_address + 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (count == '0) ? DONE : WRITE;
                end
            end
            WRITE:   if (last) state_next = READ;
            READ:    if (last) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered by loading the value for the state being entered,
    // so each bus access appears in the same cycle its state is current.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_r           <= '0;
            base_r           <= '0;
            cnt_r            <= '0;
            idx              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            rd_valid         <= 1'b0;
            rd_addr          <= '0;
            mem.m_address    <= '0;
            mem.m_writedata  <= '0;
            mem.m_byteenable <= '0;
            mem.m_chipselect <= 1'b0;
            mem.m_write      <= 1'b0;
            mem.m_clken      <= 1'b0;
        end else begin
            done             <= 1'b0;
            mem.m_clken      <= 1'b1;
            mem.m_byteenable <= '1;
            // Read data returns one cycle after the address; align the address.
            rd_valid         <= (state == READ);
            rd_addr          <= mem.m_address;
            case (state)
                IDLE: begin
                    if (accept) begin
                        seed_r <= seed;
                        base_r <= base;
                        cnt_r  <= count;
                        if (count == '0) begin
                            done <= 1'b1;
                            pass <= 1'b1;
                        end else begin
                            pass             <= 1'b0;
                            busy             <= 1'b1;
                            mem.m_chipselect <= 1'b1;
                            mem.m_write      <= 1'b1;
                            mem.m_address    <= base;
                            mem.m_writedata  <= pat(seed, base);
                            idx              <= ADDR_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (last) begin
                        mem.m_write   <= 1'b0;
                        mem.m_address <= base_r;
                        idx           <= ADDR_W'(1);
                    end else begin
                        mem.m_address   <= addr_inc;
                        mem.m_writedata <= pat(seed_r, addr_inc);
                        idx             <= idx + 1'b1;
                    end
                end
                READ: begin
                    if (last) begin
                        mem.m_chipselect <= 1'b0;
                    end else begin
                        mem.m_address <= addr_inc;
                        idx           <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    // Final word is compared this cycle; fold it into pass.
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_count == '0) && !mismatch;
                end
                default: ;
            endcase
        end
    end

    nios_memtest_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk             (clk),
        .reset           (reset),
        .clear           (accept),
        .valid           (rd_valid),
        .seed            (seed_r),
        .exp_addr        (rd_addr),
        .rdata           (mem.m_readdata),
        .mismatch        (mismatch),
        .err_count       (err_count)
`ifdef NIOS_MEMTEST_FIRST_ERR_EN
        ,
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr),
        .first_err_data  (first_err_data)
`endif
    );

endmodule

// File: tb/tb_nios_onchip_memory_tester.sv
// tb_nios_onchip_memory_tester
// Directed bench: behavioural 2048x32 RAM with optional stuck bit on word 5,
// per-run expected results queued at stimulus time and checked when done
// pulses.
module tb_nios_onchip_memory_tester;
    import nios_memtest_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] seed;
    logic [10:0] base;
    logic [11:0] count;
    logic        busy, done, pass;
    logic [11:0] err_count;
`ifdef NIOS_MEMTEST_FIRST_ERR_EN
    logic        first_err_valid;
    logic [10:0] first_err_addr;
    logic [31:0] first_err_data;
`endif

    nios_onchip_memory_tester_if #(.ADDR_W(11), .DATA_W(32)) bus ();

    nios_onchip_memory_tester #(.ADDR_W(11), .DATA_W(32), .DEPTH(2048)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .seed            (seed),
        .base            (base),
        .count           (count),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
`ifdef NIOS_MEMTEST_FIRST_ERR_EN
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr),
        .first_err_data  (first_err_data),
`endif
        .mem             (bus.master)
    );

    always #5 clk = ~clk;

    // RAM model, read latency 1; fault flips bit 0 of word 5 on read.
    logic [31:0] ram [2048];
    bit          fault = 1'b0;
    always @(posedge clk) begin
        if (bus.m_clken && bus.m_chipselect) begin
            if (bus.m_write) ram[bus.m_address] <= bus.m_writedata;
            bus.m_readdata <= ram[bus.m_address] ^
                              ((fault && bus.m_address == 11'd5) ? 32'd1 : 32'd0);
        end
    end

    typedef struct {
        logic        pass;
        logic [11:0] err;
        int          done_rel;
        int          busy_c;
        int          cs_c;
        int          wr_c;
    } exp_t;
    exp_t sb[$];

    int ntests = 0;
    int nfail  = 0;
    int wcnt [2048];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_pass"},  pass, 0);
        check({tag, "_err"},   err_count, 0);
        check({tag, "_addr"},  bus.m_address, 0);
        check({tag, "_wdata"}, bus.m_writedata, 0);
        check({tag, "_be"},    bus.m_byteenable, 0);
        check({tag, "_cs"},    bus.m_chipselect, 0);
        check({tag, "_wr"},    bus.m_write, 0);
        check({tag, "_clken"}, bus.m_clken, 0);
`ifdef NIOS_MEMTEST_FIRST_ERR_EN
        check({tag, "_fev"},   first_err_valid, 0);
        check({tag, "_fea"},   first_err_addr, 0);
        check({tag, "_fed"},   first_err_data, 0);
`endif
    endtask

    // One run: start driven at a negedge (relative cycle 0), outputs sampled
    // at every following negedge. extra > 0 pulses start again at that cycle.
    task automatic run(input string tag, input logic [31:0] sd, input logic [10:0] bs,
                       input logic [11:0] n, input bit flt, input int extra);
        exp_t e, g;
        int   rel, got, map_bad, data_bad, a, d;
        logic [11:0] eerr;
        logic        epass;
        eerr = 0;
        for (int i = 0; i < int'(n); i++)
            if (flt && ((int'(bs) + i) % 2048) == 5) eerr++;
        epass      = (eerr == 0);
        e.pass     = epass;
        e.err      = eerr;
        e.done_rel = (n == 0) ? 1 : 2 * int'(n) + 2;
        e.busy_c   = (n == 0) ? 0 : 2 * int'(n) + 1;
        e.cs_c     = 2 * int'(n);
        e.wr_c     = int'(n);
        sb.push_back(e);

        for (int i = 0; i < 2048; i++) wcnt[i] = 0;
        fault = flt;
        g.busy_c = 0; g.cs_c = 0; g.wr_c = 0; g.done_rel = -1;
        g.pass = 1'bx; g.err = 'x;
        got = 0;
        rel = 0;
        @(negedge clk);
        seed = sd; base = bs; count = n; start = 1'b1;
        while (!got && rel < 2 * int'(n) + 20) begin
            @(negedge clk);
            rel++;
            if (busy) g.busy_c++;
            if (bus.m_chipselect) g.cs_c++;
            if (bus.m_chipselect && bus.m_write) begin
                g.wr_c++;
                wcnt[bus.m_address]++;
            end
            if (done) begin
                got = 1;
                g.done_rel = rel;
                g.pass = pass;
                g.err = err_count;
            end
            // Scramble captured inputs; a mid-run start must change nothing.
            seed  = ~sd;
            base  = bs + 11'd3;
            count = 12'd5;
            start = (extra > 0 && rel == extra);
        end
        start = 1'b0;
        check({tag, "_done_seen"}, got, 1);
        e = sb.pop_front();
        check({tag, "_done_cycle"}, g.done_rel, e.done_rel);
        check({tag, "_pass"}, g.pass, e.pass);
        check({tag, "_err_count"}, g.err, e.err);
        check({tag, "_busy_cycles"}, g.busy_c, e.busy_c);
        check({tag, "_cs_cycles"}, g.cs_c, e.cs_c);
        check({tag, "_write_cycles"}, g.wr_c, e.wr_c);
        map_bad = 0;
        data_bad = 0;
        for (int i = 0; i < 2048; i++) begin
            d = (i - int'(bs) + 2048) % 2048;
            if (wcnt[i] != ((d < int'(n)) ? 1 : 0)) map_bad++;
            if (d < int'(n) && ram[i] !== (sd ^ {5'b0, 11'(i), 5'b0, 11'(i)})) data_bad++;
        end
        check({tag, "_write_map"}, map_bad, 0);
        check({tag, "_ram_data"}, data_bad, 0);
`ifdef NIOS_MEMTEST_FIRST_ERR_EN
        check({tag, "_fe_valid"}, first_err_valid, eerr != 0);
        check({tag, "_fe_addr"}, first_err_addr, (eerr != 0) ? 11'd5 : 11'd0);
        check({tag, "_fe_data"}, first_err_data, (eerr != 0) ? pat(sd, 11'd5) ^ 32'd1 : 32'd0);
`endif
        a = 0;
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_pass_held"}, pass, e.pass);
        a = a + 0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        seed  = '0;
        base  = '0;
        count = '0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        reset = 1'b0;
        @(negedge clk);
        check("clken_up", bus.m_clken, 1);
        check("be_ones", bus.m_byteenable, 4'hF);

        run("basic", 32'hA5A5_0000, 11'd0, 12'd16, 1'b0, 0);
        run("fault", 32'hA5A5_0000, 11'd0, 12'd16, 1'b1, 0);
        run("wrap",  32'h1234_5678, 11'd2040, 12'd16, 1'b0, 0);
        run("zero",  32'hDEAD_BEEF, 11'd77, 12'd0, 1'b0, 0);
        run("full",  32'h0F0F_F0F0, 11'd1000, 12'd2048, 1'b0, 0);

        // Reset in cycle 10 of a count=16 run.
        @(negedge clk);
        seed = 32'h5555_AAAA; base = 11'd100; count = 12'd16; start = 1'b1;
        for (int r = 1; r < 10; r++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        check("midrun_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check_reset_state("midrun");
        @(negedge clk);
        reset = 1'b0;

        run("after_reset", 32'h5555_AAAA, 11'd100, 12'd16, 1'b1, 0);
        run("start_busy", 32'hC3C3_3C3C, 11'd3, 12'd16, 1'b1, 7);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
